// File: rtl/window_fetch.sv
// Request sequencer for memory_access: fetches ROWS strided 48-bit rows and offers them as one window.
// Optional WAIT-state timeout is compiled in with `define WINDOW_TIMEOUT_EN.
module window_fetch #(
    parameter int ROWS           = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 SRC_SEL,
    input  logic [1:0]           MODE,
    input  logic [31:0]          BASE_INDEX,
    input  logic [31:0]          ROW_STRIDE,
    output logic                 MEM_ENABLE,
    output logic [2:0]           MEM_CTRL,
    output logic [47:0]          MEM_ADDRESS,
    input  logic [47:0]          MEM_READ,
    input  logic                 MEM_HANDSHAKE,
    output logic [48*ROWS-1:0]   WINDOW,
    output logic                 WINDOW_VALID,
    input  logic                 WINDOW_READY,
    output logic                 BUSY,
    output logic                 ERROR
);

    localparam int ROW_W = 3;
    localparam int CNT_W = 16;

    if (ROWS < 2 || ROWS > 8) begin : g_rows_range
        $error("window_fetch: ROWS must be within 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("window_fetch: TIMEOUT_CYCLES must be within 1..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_DONE
`ifdef WINDOW_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t             state_reg;
    logic [ROW_W-1:0]   row_reg;
    logic [31:0]        addr_acc_reg;
    logic [31:0]        stride_reg;
    logic [2:0]         ctrl_reg;
    logic               mem_enable_reg;
    logic [2:0]         mem_ctrl_reg;
    logic [31:0]        mem_address_reg;
    logic               window_valid_reg;
    logic               busy_reg;
    logic               capture;

    assign capture      = (state_reg == S_WAIT) && MEM_HANDSHAKE;

    assign MEM_ENABLE   = mem_enable_reg;
    assign MEM_CTRL     = mem_ctrl_reg;
    assign MEM_ADDRESS  = {16'h0000, mem_address_reg};
    assign WINDOW_VALID = window_valid_reg;
    assign BUSY         = busy_reg;

    // One 48-bit slice register per row; untouched slices keep their old contents.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_slice
            logic [47:0] slice_reg;
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    slice_reg <= '0;
                end else if (capture && (row_reg == ROW_W'(gi))) begin
                    slice_reg <= MEM_READ;
                end
            end
            assign WINDOW[48*gi +: 48] = slice_reg;
        end
    endgenerate

`ifdef WINDOW_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             error_reg;
    assign ERROR = error_reg;
`else
    assign ERROR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg        <= S_IDLE;
            row_reg          <= '0;
            addr_acc_reg     <= '0;
            stride_reg       <= '0;
            ctrl_reg         <= '0;
            mem_enable_reg   <= 1'b0;
            mem_ctrl_reg     <= '0;
            mem_address_reg  <= '0;
            window_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
`ifdef WINDOW_TIMEOUT_EN
            wait_cnt_reg     <= '0;
            error_reg        <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (START) begin
                        ctrl_reg     <= {MODE, SRC_SEL};
                        addr_acc_reg <= BASE_INDEX;
                        stride_reg   <= ROW_STRIDE;
                        row_reg      <= '0;
                        busy_reg     <= 1'b1;
`ifdef WINDOW_TIMEOUT_EN
                        error_reg    <= 1'b0;
`endif
                        state_reg    <= S_REQ;
                    end
                end
                S_REQ: begin
                    mem_enable_reg  <= 1'b1;
                    mem_ctrl_reg    <= ctrl_reg;
                    mem_address_reg <= addr_acc_reg;
`ifdef WINDOW_TIMEOUT_EN
                    wait_cnt_reg    <= '0;
`endif
                    state_reg       <= S_WAIT;
                end
                S_WAIT: begin
                    // A handshake on the timeout edge still wins.
                    if (MEM_HANDSHAKE) begin
                        mem_enable_reg <= 1'b0;
                        state_reg      <= S_GAP;
                    end
`ifdef WINDOW_TIMEOUT_EN
                    else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_enable_reg   <= 1'b0;
                        error_reg        <= 1'b1;
                        window_valid_reg <= 1'b0;
                        state_reg        <= S_ERR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (row_reg == ROW_W'(ROWS - 1)) begin
                        window_valid_reg <= 1'b1;
                        state_reg        <= S_DONE;
                    end else begin
                        row_reg      <= row_reg + 1'b1;
                        addr_acc_reg <= addr_acc_reg + stride_reg;
                        state_reg    <= S_REQ;
                    end
                end
                S_DONE: begin
                    if (WINDOW_READY) begin
                        window_valid_reg <= 1'b0;
                        busy_reg         <= 1'b0;
                        state_reg        <= S_IDLE;
                    end
                end
`ifdef WINDOW_TIMEOUT_EN
                S_ERR: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
`endif
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_fetch.sv
// Directed self-checking bench for window_fetch (ROWS=3, TIMEOUT_CYCLES=8).
module tb_window_fetch;

    localparam int ROWS = 3;
    localparam int TO   = 8;

    logic                CLK = 1'b0;
    logic                RESET = 1'b1;
    logic                START = 1'b0;
    logic                SRC_SEL = 1'b0;
    logic [1:0]          MODE = 2'b00;
    logic [31:0]         BASE_INDEX = '0;
    logic [31:0]         ROW_STRIDE = '0;
    logic                MEM_ENABLE;
    logic [2:0]          MEM_CTRL;
    logic [47:0]         MEM_ADDRESS;
    logic [47:0]         MEM_READ = '0;
    logic                MEM_HANDSHAKE = 1'b0;
    logic [48*ROWS-1:0]  WINDOW;
    logic                WINDOW_VALID;
    logic                WINDOW_READY = 1'b0;
    logic                BUSY;
    logic                ERROR;

    int n_checks = 0;
    int n_errors = 0;

    window_fetch #(.ROWS(ROWS), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SRC_SEL(SRC_SEL), .MODE(MODE),
        .BASE_INDEX(BASE_INDEX), .ROW_STRIDE(ROW_STRIDE),
        .MEM_ENABLE(MEM_ENABLE), .MEM_CTRL(MEM_CTRL), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_READ(MEM_READ), .MEM_HANDSHAKE(MEM_HANDSHAKE),
        .WINDOW(WINDOW), .WINDOW_VALID(WINDOW_VALID), .WINDOW_READY(WINDOW_READY),
        .BUSY(BUSY), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_cmd(input logic [31:0] base, input logic [31:0] stride,
                             input logic src, input logic [1:0] mode);
        BASE_INDEX = base;
        ROW_STRIDE = stride;
        SRC_SEL    = src;
        MODE       = mode;
        START      = 1'b1;
        tick();
        START      = 1'b0;
    endtask

    task automatic wait_enable(input string tag);
        for (int i = 0; i < 20 && MEM_ENABLE !== 1'b1; i++) tick();
        check({tag, "_en"}, MEM_ENABLE, 1'b1);
    endtask

    // Acts as memory_access for one row: handshake is sampled 'delay' edges after enable rose.
    task automatic serve_row(input string tag, input logic [47:0] exp_addr, input logic [2:0] exp_ctrl,
                             input logic [47:0] data, input int delay, input int r, input bit hold);
        wait_enable(tag);
        check({tag, "_addr"}, MEM_ADDRESS, exp_addr);
        check({tag, "_ctrl"}, MEM_CTRL, exp_ctrl);
        repeat (delay - 1) tick();
        MEM_HANDSHAKE = 1'b1;
        MEM_READ      = data;
        tick();
        if (!hold) MEM_HANDSHAKE = 1'b0;
        check({tag, "_en_low"}, MEM_ENABLE, 1'b0);
        check({tag, "_slice"}, WINDOW[48*r +: 48], data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [143:0] exp_win;

        // Reset state
        tick(); tick();
        RESET = 1'b0;
        check("rst_en", MEM_ENABLE, 1'b0);
        check("rst_ctrl", MEM_CTRL, 3'b000);
        check("rst_addr", MEM_ADDRESS, 48'h0);
        check("rst_window", WINDOW, 144'h0);
        check("rst_valid", WINDOW_VALID, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_error", ERROR, 1'b0);

        // Basic burst with back-pressure
        WINDOW_READY = 1'b0;
        start_cmd(32'h10, 32'd4, 1'b0, 2'b01);
        tick();
        check("start_busy", BUSY, 1'b1);
        check("start_en", MEM_ENABLE, 1'b1);
        serve_row("b0", 48'h10, 3'b010, 48'hA, 3, 0, 1'b0);
        serve_row("b1", 48'h14, 3'b010, 48'hB, 3, 1, 1'b0);
        serve_row("b2", 48'h18, 3'b010, 48'hC, 3, 2, 1'b0);
        tick();
        exp_win = {48'hC, 48'hB, 48'hA};
        check("b_valid", WINDOW_VALID, 1'b1);
        check("b_window", WINDOW, exp_win);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                BASE_INDEX = 32'h999;
                START = 1'b1;
            end
            tick();
            START = 1'b0;
            check("bp_valid", WINDOW_VALID, 1'b1);
            check("bp_window", WINDOW, exp_win);
        end
        WINDOW_READY = 1'b1;
        tick();
        check("bp_release_valid", WINDOW_VALID, 1'b0);
        check("bp_release_busy", BUSY, 1'b0);
        tick(); tick(); tick();
        check("bp_ignored_start_en", MEM_ENABLE, 1'b0);
        check("bp_ignored_start_busy", BUSY, 1'b0);

        // Wrap-around, consumer already ready
        start_cmd(32'hFFFF_FFFC, 32'd4, 1'b1, 2'b11);
        serve_row("w0", 48'h0000_FFFF_FFFC, 3'b111, 48'hD1, 2, 0, 1'b0);
        serve_row("w1", 48'h0000_0000_0000, 3'b111, 48'hD2, 2, 1, 1'b0);
        serve_row("w2", 48'h0000_0000_0004, 3'b111, 48'hD3, 2, 2, 1'b0);
        tick();
        check("w_valid", WINDOW_VALID, 1'b1);
        check("w_window", WINDOW, {48'hD3, 48'hD2, 48'hD1});
        tick();
        check("w_done_valid", WINDOW_VALID, 1'b0);
        check("w_done_busy", BUSY, 1'b0);

        // Enable gap with a handshake held for two cycles
        start_cmd(32'h100, 32'h20, 1'b0, 2'b10);
        serve_row("g0", 48'h100, 3'b100, 48'h111, 1, 0, 1'b1);
        MEM_READ = 48'hBAD;
        tick();
        MEM_HANDSHAKE = 1'b0;
        check("g_gap_en", MEM_ENABLE, 1'b0);
        check("g_stale_slice1", WINDOW[48 +: 48], 48'hD2);
        tick();
        check("g_next_en", MEM_ENABLE, 1'b1);
        check("g_stale_slice1b", WINDOW[48 +: 48], 48'hD2);
        serve_row("g1", 48'h120, 3'b100, 48'h222, 2, 1, 1'b0);
        serve_row("g2", 48'h140, 3'b100, 48'h333, 2, 2, 1'b0);
        tick();
        check("g_window", WINDOW, {48'h333, 48'h222, 48'h111});
        tick();
        check("g_done_busy", BUSY, 1'b0);

        // Reset while row 1 is in flight, then a late handshake
        start_cmd(32'h40, 32'd8, 1'b1, 2'b00);
        serve_row("r0", 48'h40, 3'b001, 48'hE0, 2, 0, 1'b0);
        wait_enable("r1");
        check("r1_addr", MEM_ADDRESS, 48'h48);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("mr_en", MEM_ENABLE, 1'b0);
        check("mr_ctrl", MEM_CTRL, 3'b000);
        check("mr_addr", MEM_ADDRESS, 48'h0);
        check("mr_window", WINDOW, 144'h0);
        check("mr_valid", WINDOW_VALID, 1'b0);
        check("mr_busy", BUSY, 1'b0);
        check("mr_error", ERROR, 1'b0);
        MEM_HANDSHAKE = 1'b1;
        MEM_READ = 48'hF00D;
        tick();
        MEM_HANDSHAKE = 1'b0;
        check("late_hs_window", WINDOW, 144'h0);
        check("late_hs_en", MEM_ENABLE, 1'b0);
        check("late_hs_busy", BUSY, 1'b0);

`ifdef WINDOW_TIMEOUT_EN
        // Timeout: no handshake ever arrives
        start_cmd(32'h80, 32'd1, 1'b0, 2'b01);
        wait_enable("t0");
        repeat (7) tick();
        check("to_pre_error", ERROR, 1'b0);
        check("to_pre_en", MEM_ENABLE, 1'b1);
        tick();
        check("to_error", ERROR, 1'b1);
        check("to_en", MEM_ENABLE, 1'b0);
        check("to_valid", WINDOW_VALID, 1'b0);
        tick();
        check("to_idle_busy", BUSY, 1'b0);
        check("to_sticky", ERROR, 1'b1);
        start_cmd(32'h0, 32'd1, 1'b0, 2'b00);
        check("to_clear", ERROR, 1'b0);
        check("to_restart_busy", BUSY, 1'b1);
`else
        // Without the timeout, WAIT blocks indefinitely
        start_cmd(32'h80, 32'd1, 1'b0, 2'b01);
        wait_enable("t0");
        repeat (20) tick();
        check("blk_en", MEM_ENABLE, 1'b1);
        check("blk_busy", BUSY, 1'b1);
        check("blk_error", ERROR, 1'b0);
`endif
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("end_busy", BUSY, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
